pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-address controller for the 5-stage core. Holds the 12-bit instruction-memory PC and selects each cycle between sequential fetch, a taken branch, a jump and a jump-register. When the pipeline is stalled, it buffers one resolved redirect and applies it on the first non-stalled cycle. It drives the F/D flush and a saturating redirect counter for performance debug.

## Interface
Parameters:
- PC_W, 12, PC / imem address width
- IMM_W, 17, branch immediate width (sign-extended)
- TGT_W, 27, jump target width (zero-extended)
- CNT_W, 16, redirect counter width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- stall  in  1  hold PC; from hazard unit / multdiv busy
- br_taken  in  1  X-stage branch resolved taken (1-cycle pulse)
- br_pc  in  PC_W  PC of the X-stage branch
- br_imm  in  IMM_W  branch immediate
- jump  in  1  X-stage j/jal (pulse)
- jump_tgt  in  TGT_W  jump target field
- jr  in  1  X-stage jr (pulse)
- jr_data  in  32  register operand for jr
- pc  out  PC_W  current fetch address
- pc_plus1  out  PC_W  pc+1, wrapped; used as the jal link value
- flush  out  1  kill F/D instructions this cycle
- pending  out  1  a buffered redirect is waiting
- redirect_cnt  out  CNT_W  applied redirects, saturating

## Operation
- Redirect request (req) = jr | jump | br_taken. Priority when more than one is asserted: jr > jump > branch.
- Targets (all results truncated to PC_W bits; wrap-around is silent):
  - branch: br_pc + 1 + sign_extend(br_imm), computed modulo 2^PC_W
  - jump: jump_tgt[PC_W-1:0] (upper bits are zero-extended, then discarded)
  - jr: jr_data[PC_W-1:0]
- States: IDLE (no pending) and HELD (pending = 1, target in pend_tgt).
- IDLE, stall = 0, req: pc <= selected target; flush = 1; counter increments.
- IDLE, stall = 0, no req: pc <= pc + 1 (wraps 0xFFF -> 0x000); flush = 0.
- IDLE, stall = 1, req: pend_tgt <= selected target; go to HELD; pc holds; flush = 0.
- IDLE, stall = 1, no req: pc holds.
- HELD, stall = 1: pc and pend_tgt hold. Any new req is ignored, because the older redirect wins and the younger instruction is wrong-path.
- HELD, stall = 0: pc <= pend_tgt; flush = 1; counter increments; go to IDLE. A req in this same cycle is ignored.
- redirect_cnt saturates at 2^CNT_W-1 and does not wrap.
- flush is combinational and equals "redirect applied this cycle", so the F/D registers clear on the same edge that pc loads.

## Timing
- Reset (reset_n = 0 at a rising edge) dominates everything. At that edge: pc = 0, pending = 0, state IDLE, redirect_cnt = 0.
- While reset_n is low: flush = 0 and pc_plus1 = 1.
- Reset asserted mid-HELD discards the buffered target.
- Redirect latency is 1 edge: a req sampled with stall = 0 is visible on pc in the next cycle.
- Stalled redirect: pc shows the target on the edge after the first stall = 0 cycle.
- pc, pending and redirect_cnt are registered. pc_plus1 and flush are combinational from the registers plus the current inputs.
- No input is registered internally. The X-stage pulses must be stable before the clock edge.

## Structure
- Shared package pc_seq_pkg holds:
  - PC_W, IMM_W, TGT_W
  - the enum redir_kind_t {RK_NONE, RK_BR, RK_J, RK_JR}
  - the state enum {S_IDLE, S_HELD}
- Sub-module pc_target_gen (combinational) takes redir_kind plus the operands and returns the PC_W target. It contains the sign/zero extension and the adder.
- Top level contains the priority encoder, FSM, PC register, pending buffer and counter.

## Test plan
- Reset then free-run with no req, stall = 0 → pc goes 0,1,2,3. Force pc = 0xFFF → next pc is 0x000 and pc_plus1 = 0x000.
- Taken branch: br_pc = 0x010, br_imm = 17'h1FFFE (-2), stall = 0 → flush = 1 that cycle, next pc = 0x00F, redirect_cnt = 1.
- Simultaneous jr (jr_data = 0xABCD1234) + jump (tgt = 0x055) + br_taken → next pc = 0x234, counter +1 only.
- Stall = 1 for 3 cycles:
  - jump tgt = 0x100 arrives in stall cycle 1 and a jr arrives in stall cycle 2.
  - Expected: pending = 1 from the next cycle, pc holds, flush stays 0.
  - First cycle with stall = 0: flush = 1, then pc = 0x100. The jr is ignored.
- Reset asserted while pending = 1 → pc = 0, pending = 0, redirect_cnt = 0. The buffered target is never applied.
- Preload redirect_cnt near max (or use CNT_W = 2), issue 5 redirects → counter sticks at 3.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared widths and enums for the fetch-address sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W  = 12;
  localparam int unsigned IMM_W = 17;
  localparam int unsigned TGT_W = 27;

  typedef enum logic [1:0] {
    RK_NONE,
    RK_BR,
    RK_J,
    RK_JR
  } redir_kind_t;

  typedef enum logic {
    S_IDLE,
    S_HELD
  } state_t;

endpackage

// File: rtl/pc_target_gen.sv
// Computes the redirect target for the selected redirect kind.
module pc_target_gen
  import pc_seq_pkg::*;
(
  input  redir_kind_t        kind,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [IMM_W-1:0]   br_imm,
  input  logic [TGT_W-1:0]   jump_tgt,
  input  logic [31:0]        jr_data,
  output logic [PC_W-1:0]    target
);

  // Sign-extend then truncate: only the low PC_W bits of the offset matter mod 2^PC_W.
  logic [PC_W-1:0] br_off;
  assign br_off = PC_W'($signed(br_imm));

  always_comb begin
    target = '0;
    case (kind)
      RK_BR:   target = br_pc + PC_W'(1) + br_off;
      RK_J:    target = PC_W'(jump_tgt);
      RK_JR:   target = PC_W'(jr_data);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with prioritised redirects, one-deep stalled-redirect buffer,
// F/D flush and a saturating redirect counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic              jump,
  input  logic [TGT_W-1:0]  jump_tgt,
  input  logic              jr,
  input  logic [31:0]       jr_data,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus1,
  output logic              flush,
  output logic              pending,
  output logic [CNT_W-1:0]  redirect_cnt
);

  state_t          state, state_nx;
  redir_kind_t     kind;
  logic            req;
  logic            apply;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pend_tgt, pend_nx, pc_nx;

  // Priority: jr > jump > branch
  always_comb begin
    kind = RK_NONE;
    if (jr)            kind = RK_JR;
    else if (jump)     kind = RK_J;
    else if (br_taken) kind = RK_BR;
  end

  assign req = (kind != RK_NONE);

  pc_target_gen u_tgt (
    .kind     (kind),
    .br_pc    (br_pc),
    .br_imm   (br_imm),
    .jump_tgt (jump_tgt),
    .jr_data  (jr_data),
    .target   (target)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      pend_tgt     <= '0;
      redirect_cnt <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      pend_tgt <= pend_nx;
      if (apply && (redirect_cnt != {CNT_W{1'b1}}))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

  // A held redirect is older than anything arriving now, so new requests are dropped in HELD.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pend_nx  = pend_tgt;
    apply    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!stall) begin
          if (req) begin
            apply = 1'b1;
            pc_nx = target;
          end else begin
            pc_nx = pc + PC_W'(1);
          end
        end else if (req) begin
          pend_nx  = target;
          state_nx = S_HELD;
        end
      end
      S_HELD: begin
        if (!stall) begin
          apply    = 1'b1;
          pc_nx    = pend_tgt;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign pending  = (state == S_HELD);
  assign flush    = reset_n & apply;
  assign pc_plus1 = reset_n ? (pc + PC_W'(1)) : PC_W'(1);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences, random vs model.
module tb_pc_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        br_taken;
  logic [11:0] br_pc;
  logic [16:0] br_imm;
  logic        jump;
  logic [26:0] jump_tgt;
  logic        jr;
  logic [31:0] jr_data;
  logic [11:0] pc;
  logic [11:0] pc_plus1;
  logic        flush;
  logic        pending;
  logic [CNT_W-1:0] redirect_cnt;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_pc        (br_pc),
    .br_imm       (br_imm),
    .jump         (jump),
    .jump_tgt     (jump_tgt),
    .jr           (jr),
    .jr_data      (jr_data),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .flush        (flush),
    .pending      (pending),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        br;
    logic [11:0] bpc;
    logic [16:0] bimm;
    logic        j;
    logic [26:0] jt;
    logic        jr;
    logic [31:0] jd;
    logic        exp_flush;
    logic [11:0] exp_pp1;
    logic [11:0] exp_pc_next;
    logic        exp_pend_next;
    int          exp_cnt_next;
  } vec_t;

  vec_t vecs[14];

  // behavioural model state
  int m_pc, m_tgt, m_cnt;
  bit m_held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [11:0] bp, input logic [16:0] bi,
                       input logic j_i, input logic [26:0] jt_i, input logic jr_i, input logic [31:0] jd_i);
    stall = s; br_taken = b; br_pc = bp; br_imm = bi;
    jump = j_i; jump_tgt = jt_i; jr = jr_i; jr_data = jd_i;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 12'h0, 17'h0, 1'b0, 27'h0, 1'b0, 32'h0);
  endtask

  // Advance one clock: inputs already driven; returns with time #1 after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int m_target(input logic b, input logic [11:0] bp, input logic [16:0] bi,
                                  input logic j_i, input logic [26:0] jt_i,
                                  input logic jr_i, input logic [31:0] jd_i);
    int off, s;
    if (jr_i) return int'(jd_i % 32'd4096);
    if (j_i)  return int'(jt_i % 27'd4096);
    off = int'(bi);
    if (bi[16]) off = off - 131072;
    s = int'(bp) + 1 + off;
    return ((s % 4096) + 4096) % 4096;
  endfunction

  initial begin
    // directed table; pc starts at 0 after reset
    vecs[0]  = '{0,0,12'h000,17'h0,0,27'h0,0,32'h0,            0,12'h001,12'h001,0,0};
    vecs[1]  = '{0,0,12'h000,17'h0,0,27'h0,0,32'h0,            0,12'h002,12'h002,0,0};
    vecs[2]  = '{0,0,12'h000,17'h0,0,27'h0,0,32'h0,            0,12'h003,12'h003,0,0};
    vecs[3]  = '{0,0,12'h000,17'h0,1,27'h0000FFF,0,32'h0,      1,12'h004,12'hFFF,0,1};
    vecs[4]  = '{0,0,12'h000,17'h0,0,27'h0,0,32'h0,            0,12'h000,12'h000,0,1};
    vecs[5]  = '{0,1,12'h010,17'h1FFFE,0,27'h0,0,32'h0,        1,12'h001,12'h00F,0,2};
    vecs[6]  = '{0,1,12'h010,17'h1FFFE,1,27'h4000055,1,32'hABCD1234, 1,12'h010,12'h234,0,3};
    vecs[7]  = '{1,0,12'h000,17'h0,1,27'h0000100,0,32'h0,      0,12'h235,12'h234,1,3};
    vecs[8]  = '{1,0,12'h000,17'h0,0,27'h0,1,32'h00000777,     0,12'h235,12'h234,1,3};
    vecs[9]  = '{1,0,12'h000,17'h0,0,27'h0,0,32'h0,            0,12'h235,12'h234,1,3};
    vecs[10] = '{0,0,12'h000,17'h0,0,27'h0,0,32'h0,            1,12'h235,12'h100,0,4};
    vecs[11] = '{1,1,12'h000,17'h00005,0,27'h0,0,32'h0,        0,12'h101,12'h100,1,4};
    vecs[12] = '{0,0,12'h000,17'h0,1,27'h00003AA,0,32'h0,      1,12'h101,12'h006,0,5};
    vecs[13] = '{0,0,12'h000,17'h0,0,27'h0,0,32'h0,            0,12'h007,12'h007,0,5};

    reset_n = 1'b0;
    idle_inputs();
    #2;
    chk("pp1_in_reset_pre_edge", 32'(pc_plus1), 32'h1);
    chk("flush_in_reset_pre_edge", 32'(flush), 32'h0);
    tick();
    tick();
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_cnt", 32'(redirect_cnt), 32'h0);
    reset_n = 1'b1;

    // table-driven directed vectors
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].bpc, vecs[i].bimm,
            vecs[i].j, vecs[i].jt, vecs[i].jr, vecs[i].jd);
      @(negedge clock);
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
      chk($sformatf("vec%0d_pc_plus1", i), 32'(pc_plus1), 32'(vecs[i].exp_pp1));
      tick();
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc_next));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend_next));
      chk($sformatf("vec%0d_cnt", i), 32'(redirect_cnt), 32'(vecs[i].exp_cnt_next));
    end

    // reset while a redirect is buffered: target must be discarded
    drive(1'b1, 1'b0, 12'h0, 17'h0, 1'b1, 27'h0000321, 1'b0, 32'h0);
    tick();
    chk("held_before_reset", 32'(pending), 32'h1);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    chk("reset_held_flush", 32'(flush), 32'h0);
    chk("reset_held_pp1", 32'(pc_plus1), 32'h1);
    tick();
    chk("reset_held_pc", 32'(pc), 32'h0);
    chk("reset_held_pending", 32'(pending), 32'h0);
    chk("reset_held_cnt", 32'(redirect_cnt), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("after_reset_no_flush", 32'(flush), 32'h0);
    tick();
    chk("after_reset_seq_pc", 32'(pc), 32'h1);

    // counter saturation
    for (int k = 0; k < CNT_MAX + 5; k++) begin
      drive(1'b0, 1'b0, 12'h0, 17'h0, 1'b1, 27'(k * 3 + 1), 1'b0, 32'h0);
      tick();
    end
    chk("cnt_saturated", 32'(redirect_cnt), 32'(CNT_MAX));
    chk("pc_after_sat_jumps", 32'(pc), 32'((CNT_MAX + 4) * 3 + 1));

    // randomized run against the behavioural model
    reset_n = 1'b0;
    idle_inputs();
    tick();
    reset_n = 1'b1;
    m_pc = 0; m_tgt = 0; m_cnt = 0; m_held = 0;
    for (int n = 0; n < 400; n++) begin
      logic s, b, j_i, jr_i;
      logic [11:0] bp;
      logic [16:0] bi;
      logic [26:0] jt_i;
      logic [31:0] jd_i;
      bit e_flush, rq;
      int t;
      s    = ($urandom_range(0, 99) < 35);
      b    = ($urandom_range(0, 99) < 25);
      j_i  = ($urandom_range(0, 99) < 15);
      jr_i = ($urandom_range(0, 99) < 15);
      bp   = 12'($urandom);
      bi   = 17'($urandom);
      jt_i = 27'($urandom);
      jd_i = $urandom;
      drive(s, b, bp, bi, j_i, jt_i, jr_i, jd_i);

      rq = b | j_i | jr_i;
      t  = m_target(b, bp, bi, j_i, jt_i, jr_i, jd_i);
      e_flush = 0;
      if (m_held) begin
        if (!s) begin
          e_flush = 1; m_pc = m_tgt; m_held = 0;
        end
      end else if (!s) begin
        if (rq) begin
          e_flush = 1; m_pc = t;
        end else begin
          m_pc = (m_pc + 1) % 4096;
        end
      end else if (rq) begin
        m_held = 1; m_tgt = t;
      end

      @(negedge clock);
      chk("rnd_flush", 32'(flush), 32'(e_flush));
      chk("rnd_pc_plus1", 32'(pc_plus1), 32'((int'(pc) + 1) % 4096));
      tick();
      if (e_flush && m_cnt < CNT_MAX) m_cnt++;
      chk("rnd_pc", 32'(pc), 32'(m_pc));
      chk("rnd_pending", 32'(pending), 32'(m_held));
      chk("rnd_cnt", 32'(redirect_cnt), 32'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
